// File: rtl/hs_pkg.sv
// hs_pkg: shared definitions for the hiscore access arbiter.
//   - hs_state_e : arbiter FSM states (IDLE..RELEASE)
//   - HS_STATE_W : width of the state encoding
//   - HS_SETTLE_DEF / HS_HOLDOFF_DEF : default settle / hold-off cycle counts
//   - hs_max()   : elaboration-time helper for sizing the shared counter
package hs_pkg;

  localparam int HS_STATE_W     = 3;
  localparam int HS_SETTLE_DEF  = 4;
  localparam int HS_HOLDOFF_DEF = 4;

  typedef enum logic [HS_STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_PAUSING  = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_GRANT    = 3'd3,
    ST_HANDOVER = 3'd4,
    ST_RELEASE  = 3'd5
  } hs_state_e;

  function automatic int hs_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hs_rr_pick.sv
// hs_rr_pick: combinational round-robin picker.
//   req    : request vector
//   rr_ptr : highest-priority index this round
//   idx    : first set request at or after rr_ptr, wrapping modulo NREQ
//   valid  : at least one request is set
module hs_rr_pick
  import hs_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  // Scan offsets 0..NREQ-1 from rr_ptr; the first hit wins. The modulo keeps
  // the wrap correct for NREQ that is not a power of two.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid && req[(int'(rr_ptr) + k) % NREQ]) begin
        valid = 1'b1;
        idx   = PW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/hiscore_access_arbiter.sv
// hiscore_access_arbiter: shares the game's hiscore RAM port between NREQ
// requesters. Pauses the CPU, waits for confirmation plus a settle delay,
// then grants one requester at a time in round-robin order.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req/req_addr/req_we/req_data : per-requester level request and RAM path
//   grant               : registered one-hot grant
//   ram_addr/ram_we/ram_din : muxed RAM path of the granted requester (0 if none)
//   cpu_pause / cpu_paused  : pause request to core / core confirmation
//   busy                : FSM not in IDLE
//   timeout_err         : sticky watchdog flag
//
// Build option: define HSARB_WATCHDOG_EN to enable the TIMEOUT watchdog on the
// pause handshake; otherwise timeout_err is tied 0 and PAUSING waits forever.
module hiscore_access_arbiter
  import hs_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ADDRWIDTH = 16,
  parameter int SETTLE    = HS_SETTLE_DEF,
  parameter int HOLDOFF   = HS_HOLDOFF_DEF,
  parameter int TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ*8-1:0]         req_data,
  output logic [NREQ-1:0]           grant,
  output logic [ADDRWIDTH-1:0]      ram_addr,
  output logic                      ram_we,
  output logic [7:0]                ram_din,
  output logic                      cpu_pause,
  input  logic                      cpu_paused,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = hs_max(SETTLE, HOLDOFF);
  localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;

  hs_state_e       state;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   next_ptr;
  logic [PW-1:0]   pick_idx;
  logic            pick_vld;
  logic [CW-1:0]   cnt;
  logic            others;

  hs_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  // Explicit wrap so non-power-of-two NREQ never lands on an unused index.
  assign next_ptr = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
  assign others   = |(req & ~(NREQ'(1) << winner));
  assign busy     = (state != ST_IDLE);

`ifdef HSARB_WATCHDOG_EN
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WW-1:0] wd_cnt;
  logic          terr;
  assign timeout_err = terr;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      winner    <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      grant     <= '0;
      cpu_pause <= 1'b0;
`ifdef HSARB_WATCHDOG_EN
      wd_cnt    <= '0;
      terr      <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            winner    <= pick_idx;
            cpu_pause <= 1'b1;
            state     <= ST_PAUSING;
`ifdef HSARB_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
          end
        end
        ST_PAUSING: begin
          if (!req[winner]) begin
            cnt   <= CW'(HOLDOFF);
            state <= ST_RELEASE;
          end else if (cpu_paused) begin
            cnt   <= CW'(SETTLE);
            state <= ST_SETTLE;
          end
`ifdef HSARB_WATCHDOG_EN
          else if (wd_cnt == WW'(TIMEOUT - 1)) begin
            // Core never acknowledged: give up without hold-off and move the
            // pointer so the stuck requester does not starve the others.
            terr      <= 1'b1;
            cpu_pause <= 1'b0;
            rr_ptr    <= next_ptr;
            state     <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
`endif
        end
        ST_SETTLE: begin
          if (!req[winner]) begin
            cnt   <= CW'(HOLDOFF);
            state <= ST_RELEASE;
          end else if (cnt == '0) begin
            grant <= NREQ'(1) << winner;
            state <= ST_GRANT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_GRANT: begin
          if (!req[winner]) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
            if (others) begin
              state <= ST_HANDOVER;
            end else begin
              cnt   <= CW'(HOLDOFF);
              state <= ST_RELEASE;
            end
          end
        end
        ST_HANDOVER: begin
          // Pause stays asserted; only the settle delay is repeated.
          if (pick_vld) begin
            winner <= pick_idx;
            cnt    <= CW'(SETTLE);
            state  <= ST_SETTLE;
          end else begin
            cnt   <= CW'(HOLDOFF);
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (cnt == '0) begin
            cpu_pause <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          grant     <= '0;
          cpu_pause <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM path follows the registered grant with no extra latency.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (|grant) begin
      ram_addr = req_addr[int'(winner)*ADDRWIDTH +: ADDRWIDTH];
      ram_din  = req_data[int'(winner)*8 +: 8];
      ram_we   = req_we[winner] & grant[winner];
    end
  end

endmodule

// File: tb/tb_hiscore_access_arbiter.sv
module tb_hiscore_access_arbiter;

  localparam int NREQ    = 2;
  localparam int AW      = 16;
  localparam int SETTLE  = 4;
  localparam int HOLDOFF = 4;
  localparam int TIMEOUT = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*8-1:0]  req_data;
  logic [NREQ-1:0]    grant;
  logic [AW-1:0]      ram_addr;
  logic               ram_we;
  logic [7:0]         ram_din;
  logic               cpu_pause;
  logic               cpu_paused;
  logic               busy;
  logic               timeout_err;

  hiscore_access_arbiter #(
    .NREQ(NREQ), .ADDRWIDTH(AW), .SETTLE(SETTLE), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_we(req_we),
    .req_data(req_data), .grant(grant), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .cpu_pause(cpu_pause), .cpu_paused(cpu_paused), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (timestamp based) ----------------
  // Phases of a pause session; deadlines are absolute cycle numbers.
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_SETL = 2, PH_OWN = 3, PH_GAP = 4, PH_COOL = 5;
  int            m_ph = PH_IDLE;
  int            m_win = 0;
  int            m_ptr = 0;
  int            m_due = 0;
  int            m_cyc = 0;
  logic [NREQ-1:0] m_gnt = '0;
  logic          m_pause = 1'b0;
  logic          m_terr = 1'b0;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (reset) begin
      m_ph = PH_IDLE; m_win = 0; m_ptr = 0; m_cyc = 0;
      m_gnt = '0; m_pause = 1'b0; m_terr = 1'b0;
      return;
    end
    m_cyc++;
    case (m_ph)
      PH_IDLE: begin
        w = rr_pick(req, m_ptr);
        if (w >= 0) begin
          m_win = w; m_pause = 1'b1; m_ph = PH_WAIT; m_due = m_cyc + TIMEOUT;
        end
      end
      PH_WAIT: begin
        if (!req[m_win]) begin
          m_ph = PH_COOL; m_due = m_cyc + HOLDOFF + 1;
        end else if (cpu_paused) begin
          m_ph = PH_SETL; m_due = m_cyc + SETTLE + 1;
        end
`ifdef HSARB_WATCHDOG_EN
        else if (m_cyc == m_due) begin
          m_terr = 1'b1; m_pause = 1'b0; m_ptr = (m_win + 1) % NREQ; m_ph = PH_IDLE;
        end
`endif
      end
      PH_SETL: begin
        if (!req[m_win]) begin
          m_ph = PH_COOL; m_due = m_cyc + HOLDOFF + 1;
        end else if (m_cyc == m_due) begin
          m_gnt = '0; m_gnt[m_win] = 1'b1; m_ph = PH_OWN;
        end
      end
      PH_OWN: begin
        if (!req[m_win]) begin
          m_gnt = '0;
          m_ptr = (m_win + 1) % NREQ;
          if (rr_pick(req, m_ptr) >= 0 && rr_pick(req, m_ptr) != m_win) m_ph = PH_GAP;
          else begin m_ph = PH_COOL; m_due = m_cyc + HOLDOFF + 1; end
        end
      end
      PH_GAP: begin
        w = rr_pick(req, m_ptr);
        if (w >= 0) begin m_win = w; m_ph = PH_SETL; m_due = m_cyc + SETTLE + 1; end
        else begin m_ph = PH_COOL; m_due = m_cyc + HOLDOFF + 1; end
      end
      PH_COOL: begin
        if (m_cyc == m_due) begin m_pause = 1'b0; m_ph = PH_IDLE; end
      end
      default: m_ph = PH_IDLE;
    endcase
  endtask

  // Compare every cycle on the inactive edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_grant", grant, m_gnt);
      chk("m_pause", cpu_pause, m_pause);
      chk("m_busy", busy, m_ph != PH_IDLE);
      chk("m_terr", timeout_err, m_terr);
      if (m_gnt != '0) begin
        chk("m_addr", ram_addr, req_addr[m_win*AW +: AW]);
        chk("m_din", ram_din, req_data[m_win*8 +: 8]);
        chk("m_we", ram_we, req_we[m_win]);
      end else begin
        chk("m_addr0", ram_addr, 0);
        chk("m_din0", ram_din, 0);
        chk("m_we0", ram_we, 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_we = '0; cpu_paused = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Cycles after the first edge that sees the current inputs until grant==want.
  task automatic wait_grant(input logic [NREQ-1:0] want, input int maxc, output int lat);
    int k = 0;
    lat = -1;
    while (k < maxc) begin
      step(); k++;
      if (grant == want) begin lat = k - 1; break; end
    end
  endtask

  task automatic wait_pause_low(input int maxc, output int lat);
    int k = 0;
    lat = -1;
    while (k < maxc) begin
      step(); k++;
      if (!cpu_pause) begin lat = k - 1; break; end
    end
  endtask

  task automatic wait_any_grant(input int maxc, output logic [NREQ-1:0] g);
    int k = 0;
    g = '0;
    while (k < maxc) begin
      step(); k++;
      if (grant != '0) begin g = grant; break; end
    end
  endtask

  int life [NREQ];

  initial begin
    int lat;
    int k;
    logic seen_g, seen_we, pause_low;
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] r;

    reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_data = '0; cpu_paused = 1'b0;
    step(); step();
    reset = 1'b0;
    chk_on = 1'b1;

    // Reset state
    chk("rst_grant", grant, 0);
    chk("rst_pause", cpu_pause, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);

    // Single request
    req = 2'b01;
    step();
    chk("single_pause_up", cpu_pause, 1);
    step(); step(); step();
    cpu_paused = 1'b1;
    wait_grant(2'b01, 40, lat);
    chk("single_settle_lat", lat, SETTLE + 1);
    req = 2'b00;
    wait_pause_low(40, lat);
    chk("single_holdoff_lat", lat, HOLDOFF + 1);
    cpu_paused = 1'b0;
    chk("single_idle_busy", busy, 0);

    // Contention from reset: requester 0 first, then handover without unpause
    do_reset();
    req = 2'b11;
    step();
    cpu_paused = 1'b1;
    wait_grant(2'b01, 40, lat);
    chk("cont_first_lat", lat, SETTLE + 1);
    req = 2'b10;
    step();
    chk("cont_gap_grant", grant, 0);
    k = 1; pause_low = !cpu_pause;
    while (grant != 2'b10 && k < 40) begin
      step(); k++;
      if (!cpu_pause) pause_low = 1'b1;
    end
    chk("cont_handover_lat", k - 1, SETTLE + 2);
    chk("cont_pause_held", pause_low, 0);
    req = 2'b00;
    wait_pause_low(40, lat);
    cpu_paused = 1'b0;

    // Round-robin fairness over 6 sessions
    do_reset();
    req = 2'b11;
    step();
    cpu_paused = 1'b1;
    for (int s = 0; s < 6; s++) begin
      wait_any_grant(60, g);
      chk($sformatf("rr_%0d", s), g, (s % 2) ? 2'b10 : 2'b01);
      step(); step();
      req = req & ~g;
      step();
      req = 2'b11;
    end
    req = 2'b00;
    wait_pause_low(60, lat);
    chk("rr_end_release", lat >= 0, 1);
    cpu_paused = 1'b0;

    // Abort during SETTLE; req_we high on both with no grant
    do_reset();
    req_we = 2'b11;
    req = 2'b10;
    step();
    cpu_paused = 1'b1;
    step(); step();
    chk("dp_we_nogrant", ram_we, 0);
    req = 2'b00;
    seen_g = 1'b0; seen_we = 1'b0; lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (grant != '0) seen_g = 1'b1;
      if (ram_we) seen_we = 1'b1;
      if (!cpu_pause) begin lat = i - 1; break; end
    end
    chk("abort_grant_seen", seen_g, 0);
    chk("abort_we_seen", seen_we, 0);
    chk("abort_lat", lat, HOLDOFF + 1);
    cpu_paused = 1'b0;

    // Datapath for requester 1
    do_reset();
    req_addr = {16'h1234, 16'h5a5a};
    req_data = {8'hA5, 8'h3C};
    req_we = 2'b11;
    req = 2'b10;
    step();
    cpu_paused = 1'b1;
    wait_grant(2'b10, 40, lat);
    chk("dp_grant_lat", lat, SETTLE + 1);
    chk("dp_addr", ram_addr, 16'h1234);
    chk("dp_din", ram_din, 8'hA5);
    chk("dp_we", ram_we, 1);
    req_we = 2'b01;
    #1;
    chk("dp_we_off", ram_we, 0);

    // Synchronous reset while granted
    reset = 1'b1;
    step();
    chk("rst_mid_grant", grant, 0);
    chk("rst_mid_pause", cpu_pause, 0);
    reset = 1'b0; req = '0; cpu_paused = 1'b0;
    step();

`ifdef HSARB_WATCHDOG_EN
    // Watchdog: core never confirms
    do_reset();
    req = 2'b01;
    step();
    k = 0;
    while (!timeout_err && k < TIMEOUT + 10) begin step(); k++; end
    chk("wd_lat", k, TIMEOUT);
    chk("wd_pause", cpu_pause, 0);
    chk("wd_busy", busy, 0);
    step();
    chk("wd_rereq", cpu_pause, 1);
    chk("wd_sticky", timeout_err, 1);
    req = 2'b00;
    wait_pause_low(40, lat);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < NREQ; i++) life[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      r = req;
      for (int i = 0; i < NREQ; i++) begin
        if (!r[i]) begin
          if ($urandom_range(0, 5) == 0) begin r[i] = 1'b1; life[i] = $urandom_range(1, 5); end
        end else if (grant[i]) begin
          life[i]--;
          if (life[i] <= 0) r[i] = 1'b0;
        end else if ($urandom_range(0, 30) == 0) begin
          r[i] = 1'b0;
        end
        req_addr[i*AW +: AW] = AW'($urandom);
        req_data[i*8 +: 8]   = 8'($urandom);
        req_we[i]            = 1'($urandom);
      end
      req = r;
      if (!cpu_pause) cpu_paused = 1'b0;
      else if (!cpu_paused) begin
        if ($urandom_range(0, 2) == 0) cpu_paused = 1'b1;
      end else if ($urandom_range(0, 19) == 0) cpu_paused = 1'b0;
    end

    step();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hiscore_access_arbiter.md
Name: hiscore_access_arbiter

Overview:
- Shares the game's hiscore RAM port between NREQ requesters, such as the hiscore restore/save engine and the NVRAM extract engine.
- Requests a CPU pause from the core and waits for the core's paused confirmation.
- After a settle delay, grants one requester at a time, in round-robin order, the RAM address/write/data path.
- Sits between the requester modules and the core's hiscore RAM port mux.

Parameters:
NREQ, 2, number of requesters (2..4)
ADDRWIDTH, 16, game RAM address width
SETTLE, 4, cycles to wait after cpu_paused seen before grant
HOLDOFF, 4, cycles pause is held after last grant released
TIMEOUT, 1024, watchdog limit in cycles (used only with optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NREQ  level request per requester, held high until access finished
req_addr  in  NREQ*ADDRWIDTH  flattened per-requester address, slice i = [i*ADDRWIDTH +: ADDRWIDTH]
req_we  in  NREQ  per-requester write strobe
req_data  in  NREQ*8  flattened per-requester write data
grant  out  NREQ  one-hot grant, registered
ram_addr  out  ADDRWIDTH  muxed address to game RAM port
ram_we  out  1  muxed write strobe, gated by grant
ram_din  out  8  muxed write data
cpu_pause  out  1  pause request to core, registered
cpu_paused  in  1  core confirms CPU halted
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky watchdog flag (optional feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, counters 0. Reset mid-operation drops grant and cpu_pause on the next edge, with no HOLDOFF.
- States: IDLE, PAUSING, SETTLE, GRANT, HANDOVER, RELEASE.
- IDLE:
  - On any req bit, select winner = first set bit at or after rr_ptr, wrapping modulo NREQ.
  - Latch the winner index, set cpu_pause=1, go to PAUSING.
- PAUSING:
  - Hold cpu_pause.
  - When cpu_paused=1, load counter=SETTLE and go to SETTLE.
  - If the winner's req drops first, go to RELEASE.
- SETTLE:
  - Decrement the counter.
  - At 0, assert grant[winner] on the next edge and go to GRANT.
  - Winner req drop aborts to RELEASE.
- GRANT:
  - grant held while req[winner]=1.
  - On req[winner]=0: clear grant and set rr_ptr=(winner+1) mod NREQ.
  - If any other req bit is set, go to HANDOVER with cpu_pause kept high.
  - Otherwise load counter=HOLDOFF and go to RELEASE.
- HANDOVER:
  - Exactly one cycle with grant=0.
  - Select the next winner by round-robin from the updated rr_ptr.
  - Go to SETTLE with counter=SETTLE. No pause re-handshake.
- RELEASE:
  - cpu_pause stays 1 until the counter reaches 0, then cpu_pause=0 and go to IDLE.
  - A new req arriving in RELEASE is not serviced until IDLE; there is a minimum 1-cycle gap with cpu_pause=0.
- Data path:
  - ram_addr/ram_din are the winner's slices when a grant bit is set, else 0.
  - ram_we = req_we[winner] & grant[winner]. Combinational from the registered grant, zero added latency.
- cpu_paused falling during SETTLE or GRANT is ignored; the arbiter owns the pause.
- Simultaneous requests resolve by rr_ptr. After reset, requester 0 wins a tie.
- Arithmetic:
  - Counters are sized $clog2(max(SETTLE,HOLDOFF)+1).
  - SETTLE=0 means grant on the edge after cpu_paused is seen.
  - rr_ptr is $clog2(NREQ) bits and wraps explicitly, not by overflow, when NREQ is not a power of 2.

Optional Feature:
- Macro: HSARB_WATCHDOG_EN.
- With the macro:
  - A TIMEOUT-cycle counter runs in PAUSING.
  - If cpu_paused is not seen before expiry: set timeout_err (sticky until reset), drop cpu_pause, advance rr_ptr past the winner, go to IDLE.
  - The same requester can re-request afterwards.
- Without the macro: no counter; timeout_err is tied 0; PAUSING waits indefinitely.

Decomposition:
- Shared package hs_pkg:
  - state enum/localparams for IDLE..RELEASE and state width;
  - default SETTLE/HOLDOFF values.
- One sub-module, hs_rr_pick: combinational round-robin picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: winner index and a valid flag.
  - Reused by IDLE and HANDOVER.

Test Plan:
- Single request:
  - Stimulus: req=01; cpu_paused rises 3 cycles after cpu_pause.
  - Expect: grant=01 exactly SETTLE+1 cycles after cpu_paused.
  - Expect: after req drops, cpu_pause falls HOLDOFF+1 cycles later and busy=0 in IDLE.
- Contention:
  - Stimulus: req=11 from reset.
  - Expect: requester 0 is granted first.
  - Expect: when req[0] drops, one cycle with grant=00, cpu_pause never falls, then grant=10 after SETTLE.
- Round-robin fairness:
  - Stimulus: 6 back-to-back sessions with both requests continuously re-asserted.
  - Expect: grants alternate 01,10,01,10,01,10.
- Abort:
  - Stimulus: req[1] drops during SETTLE.
  - Expect: no grant pulse; RELEASE runs HOLDOFF; cpu_pause=0; ram_we never asserted.
- Datapath:
  - Stimulus: requester 1 granted with req_addr slice 1=16'h1234, req_data=8'hA5, req_we=1.
  - Expect: ram_addr=16'h1234, ram_din=8'hA5, ram_we=1 on the same cycle.
  - Expect: req_we[0]=1 with no grant gives ram_we=0.
- Reset and watchdog:
  - Stimulus: synchronous reset during GRANT.
  - Expect: grant=0 and cpu_pause=0 on the next edge.
  - Stimulus (HSARB_WATCHDOG_EN only): cpu_paused held 0.
  - Expect: timeout_err=1 after TIMEOUT cycles, cpu_pause drops, state returns to IDLE.
